fifo_fwft_rd_stage: RTL and testbench

- Read-side stage directly downstream of the 256x32b sync FIFO controller and its block RAM.
- Converts standard-mode reads (rempty / r_en / delayed rdata) into a first-word-fall-through valid/ready stream for the consumer logic.
- Holds a small prefetch buffer so that a continuously-ready consumer receives one word per cycle.
- fifo_ren is driven only from registered state, so there is no combinational path from m_ready to the FIFO.

---
 rtl/fifo_fwft_rd_stage.sv | 138 +++++++++++++
 tb/tb_fifo_fwft_rd_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_rd_stage.sv
// First-word-fall-through read stage behind a standard-mode sync FIFO and its block RAM.
// A small prefetch buffer sustains one word per cycle while fifo_ren stays registered-only.

module fifo_fwft_rd_stage_chk #(
    parameter int BUF_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture,
    input  logic       pop,
    input  logic [2:0] level
);

    // A capture into a full buffer without a pop would overwrite the head word.
    property no_overflow;
        @(posedge clk) disable iff (!rst_n)
            !(capture && !pop && (level == 3'(BUF_DEPTH)));
    endproperty

    assert property (no_overflow)
        else $error("fifo_fwft_rd_stage: prefetch buffer overflow");

endmodule

module fifo_fwft_rd_stage #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int RAM_RD_LATENCY = 1,
    localparam int BUF_DEPTH      = RAM_RD_LATENCY + 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  flush,
    input  logic                  fifo_rempty,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [2:0]            buf_level
);

    localparam int                LAT      = RAM_RD_LATENCY;
    localparam int                PTR_W    = $clog2(BUF_DEPTH);
    localparam logic [3:0]        DEPTH_C  = 4'(BUF_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    function automatic logic [3:0] popcount(input logic [LAT-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < LAT; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic                  run_r;
    logic [LAT-1:0]        inflight_r;
    logic [LAT-1:0]        inflight_next_s;
    logic [DATA_WIDTH-1:0] buf_r [BUF_DEPTH];
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [2:0]            level_r;
    logic [3:0]            occupancy_s;
    logic                  issue_s;
    logic                  capture_s;
    logic                  pop_s;

    // Issue, capture and pop decisions; issue never looks at m_ready.
    always_comb begin
        occupancy_s = {1'b0, level_r} + popcount(inflight_r);
        issue_s     = run_r && !fifo_rempty && !flush && (occupancy_s < DEPTH_C);
        capture_s   = inflight_r[LAT-1] && !flush;
        pop_s       = m_valid && m_ready;
    end

    if (LAT == 1) begin : g_shift_one
        assign inflight_next_s = issue_s;
    end else begin : g_shift_many
        assign inflight_next_s = {inflight_r[LAT-2:0], issue_s};
    end

    assign fifo_ren  = issue_s;
    assign m_valid   = (level_r != 3'd0);
    assign m_data    = buf_r[rptr_r];
    assign buf_level = level_r;

    // run_r holds off issue for the first cycle after reset release.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            run_r      <= 1'b0;
            inflight_r <= {LAT{1'b0}};
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            level_r    <= 3'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (flush) begin
            run_r      <= 1'b1;
            inflight_r <= {LAT{1'b0}};
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            level_r    <= 3'd0;
        end else begin
            run_r      <= 1'b1;
            inflight_r <= inflight_next_s;
            if (capture_s) begin
                buf_r[wptr_r] <= fifo_rdata;
                wptr_r        <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            level_r <= level_r + {2'b00, capture_s} - {2'b00, pop_s};
        end
    end

    fifo_fwft_rd_stage_chk #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_chk (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .capture (capture_s),
        .pop     (pop_s),
        .level   (level_r)
    );

endmodule

// File: tb/tb_fifo_fwft_rd_stage.sv
// Scoreboard bench: two stages (RAM latency 1 and 2) share stimulus, each fed by a FIFO/RAM model.
module tb_fifo_fwft_rd_stage;

    localparam int NL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rrst_n;
    logic          flush;
    logic          m_ready;
    logic [NL-1:0] rempty;
    logic [NL-1:0] ren;
    logic [NL-1:0] mvalid;
    logic [31:0]   rdata [NL];
    logic [31:0]   mdata [NL];
    logic [2:0]    level [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        fifo_fwft_rd_stage #(
            .DATA_WIDTH     (32),
            .RAM_RD_LATENCY (g + 1)
        ) dut (
            .rclk        (clk),
            .rrst_n      (rrst_n),
            .flush       (flush),
            .fifo_rempty (rempty[g]),
            .fifo_ren    (ren[g]),
            .fifo_rdata  (rdata[g]),
            .m_valid     (mvalid[g]),
            .m_data      (mdata[g]),
            .m_ready     (m_ready),
            .buf_level   (level[g])
        );
    end

    // FIFO contents are shared; each lane reads them at its own pace.
    logic [31:0] fifo_mem [0:2047];
    int          fifo_wr;
    int          fifo_rd    [NL];
    int          exp_head   [NL];
    int          pipe_idx   [NL][3];
    bit          pipe_v     [NL][3];
    bit          pipe_live  [NL][3];
    bit          issue_now  [NL];
    bit          issue_live [NL];
    int          issue_idx  [NL];
    bit          first_seen [NL];
    bit          first_arm  [NL];
    int          rel_cyc;
    bit          final_chk;
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d (lat %0d) t=%0t: got %0h, expected %0h", name, lane, lane + 1, $time, act, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[fifo_wr] = $urandom();
            fifo_wr++;
        end
    endtask

    // Monitor + FIFO/RAM model: sample just before each rising edge, update just after it.
    initial begin
        int lat;
        int live;
        int outstanding;
        int exp_level;
        bit exp_ren;
        n_vec   = 0;
        n_err   = 0;
        rel_cyc = -1;
        rempty  = '1;
        for (int l = 0; l < NL; l++) begin
            rdata[l]      = 32'd0;
            fifo_rd[l]    = 0;
            exp_head[l]   = 0;
            issue_now[l]  = 1'b0;
            issue_live[l] = 1'b0;
            issue_idx[l]  = 0;
            first_seen[l] = 1'b0;
            first_arm[l]  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                pipe_v[l][k]    = 1'b0;
                pipe_live[l][k] = 1'b0;
                pipe_idx[l][k]  = 0;
            end
        end
        forever begin
            @(negedge clk);
            #3;
            if (!rrst_n) rel_cyc = -1;
            else         rel_cyc++;
            for (int l = 0; l < NL; l++) begin
                lat          = l + 1;
                issue_now[l] = 1'b0;
                if (!rrst_n) begin
                    check("reset_fifo_ren", l, 32'(ren[l]), 32'd0);
                    check("reset_m_valid", l, 32'(mvalid[l]), 32'd0);
                    check("reset_buf_level", l, 32'(level[l]), 32'd0);
                    check("reset_m_data", l, mdata[l], 32'd0);
                    exp_head[l]   = fifo_rd[l];
                    first_seen[l] = 1'b0;
                    first_arm[l]  = 1'b0;
                    for (int k = 0; k < 3; k++) pipe_live[l][k] = 1'b0;
                end else begin
                    live = 0;
                    for (int k = 0; k < lat; k++) begin
                        if (pipe_v[l][k] && pipe_live[l][k]) live++;
                    end
                    outstanding = fifo_rd[l] - exp_head[l];
                    exp_level   = outstanding - live;
                    if (rel_cyc == 0) first_arm[l] = !rempty[l];
                    check("buf_level", l, 32'(level[l]), 32'(exp_level));
                    check("m_valid", l, 32'(mvalid[l]), 32'(exp_level != 0));
                    exp_ren = !rempty[l] && !flush && (rel_cyc >= 1) && (outstanding < lat + 2);
                    check("fifo_ren", l, 32'(ren[l]), 32'(exp_ren));
                    if (mvalid[l] && !first_seen[l]) begin
                        first_seen[l] = 1'b1;
                        if (first_arm[l]) check("first_valid_latency", l, 32'(rel_cyc), 32'(lat + 2));
                    end
                    if (mvalid[l] && m_ready) begin
                        if (exp_head[l] < fifo_rd[l]) begin
                            check("m_data", l, mdata[l], fifo_mem[exp_head[l]]);
                            exp_head[l]++;
                        end else begin
                            check("unexpected_word", l, 32'd1, 32'd0);
                        end
                    end
                    if (ren[l] && (fifo_rd[l] < fifo_wr)) begin
                        issue_now[l]  = 1'b1;
                        issue_idx[l]  = fifo_rd[l];
                        issue_live[l] = !flush;
                        fifo_rd[l]++;
                    end
                    if (flush) begin
                        exp_head[l] = fifo_rd[l];
                        for (int k = 0; k < 3; k++) pipe_live[l][k] = 1'b0;
                    end
                    if (final_chk) check("undelivered_words", l, 32'(fifo_wr - exp_head[l]), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            for (int l = 0; l < NL; l++) begin
                lat = l + 1;
                for (int k = lat - 1; k > 0; k--) begin
                    pipe_v[l][k]    = pipe_v[l][k-1];
                    pipe_idx[l][k]  = pipe_idx[l][k-1];
                    pipe_live[l][k] = pipe_live[l][k-1];
                end
                pipe_v[l][0]    = issue_now[l];
                pipe_idx[l][0]  = issue_idx[l];
                pipe_live[l][0] = issue_live[l];
                rdata[l]  = pipe_v[l][lat-1] ? fifo_mem[pipe_idx[l][lat-1]] : $urandom();
                rempty[l] = (fifo_rd[l] >= fifo_wr);
            end
        end
    end

    // Stimulus: directed phases followed by a randomized run and a mid-stream reset.
    initial begin
        rrst_n    = 1'b0;
        flush     = 1'b0;
        m_ready   = 1'b1;
        final_chk = 1'b0;
        fifo_wr   = 0;
        for (int i = 0; i < 5; i++) begin
            fifo_mem[i] = 32'(i);
        end
        fifo_wr = 5;
        repeat (3) @(negedge clk);
        rrst_n = 1'b1;
        repeat (12) @(negedge clk);

        m_ready = 1'b0;
        push(8);
        repeat (10) @(negedge clk);
        m_ready = 1'b1;
        repeat (14) @(negedge clk);

        push(16);
        for (int i = 0; i < 60; i++) begin
            m_ready = (i % 2 == 0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        repeat (4) @(negedge clk);

        m_ready = 1'b0;
        push(6);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 500; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) push($urandom_range(1, 2));
            @(negedge clk);
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (20) @(negedge clk);

        m_ready = 1'b0;
        push(10);
        repeat (7) @(negedge clk);
        rrst_n = 1'b0;
        repeat (2) @(negedge clk);
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        repeat (30) @(negedge clk);

        final_chk = 1'b1;
        @(negedge clk);
        final_chk = 1'b0;
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
